// File: rtl/csa_seq_pkg.sv
// Shared types and constants for the sequential wide carry-select adder.
package csa_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } csa_state_t;

    localparam int CSA_SLICE_W = 16;

    // Word-counter width; never below one bit so the counter always exists.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/csa_wide_add_seq_slice.sv
// 16-bit carry-select adder slice: each 4-bit group precomputes its sum and a
// binary-to-excess-1 (+1) variant, and the incoming carry picks between them.
module Select_Carry_Adder (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        cin,
    output logic        cout,
    output logic [15:0] sum
);

    logic [4:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[4];

    for (genvar g = 0; g < 4; g++) begin : g_grp
        logic [4:0] raw;
        logic [4:0] bec;

        assign raw = {1'b0, A[g*4 +: 4]} + {1'b0, B[g*4 +: 4]};
        assign bec = raw + 5'd1;
        assign {carry[g+1], sum[g*4 +: 4]} = carry[g] ? bec : raw;
    end

endmodule

// File: rtl/csa_wide_add_seq.sv
// WORDS x 16-bit adder that time-multiplexes one carry-select slice, LSW first.
// Define CSA_SEQ_SUB_EN to add the sub input (a - b via ~b and a forced carry-in).
module csa_wide_add_seq
    import csa_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [CSA_SLICE_W*WORDS-1:0] a,
    input  logic [CSA_SLICE_W*WORDS-1:0] b,
    input  logic                         cin,
`ifdef CSA_SEQ_SUB_EN
    input  logic                         sub,
`endif
    output logic                         busy,
    output logic                         done,
    output logic [CSA_SLICE_W*WORDS-1:0] sum,
    output logic                         cout,
    output logic                         ovf
);

    localparam int N  = CSA_SLICE_W * WORDS;
    localparam int CW = clog2(WORDS);
    localparam logic [CW-1:0] LAST_WORD = CW'(WORDS - 1);

    csa_state_t state_q, state_d;
    logic             accept;
    logic             last;

    logic [N-1:0]     a_q, b_q, res_q, res_d;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [N-1:0]     b_eff;
    logic             c_init;

    logic [CSA_SLICE_W-1:0] slice_sum;
    logic                   slice_cout;
    logic                   msb_cin;

    logic [N-1:0]     sum_q;
    logic             cout_q, ovf_q;

`ifdef CSA_SEQ_SUB_EN
    assign b_eff  = sub ? ~b : b;
    assign c_init = sub | cin;
`else
    assign b_eff  = b;
    assign c_init = cin;
`endif

    assign last = (state_q == RUN) && (cnt_q == LAST_WORD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    Select_Carry_Adder u_slice (
        .A    (a_q[CSA_SLICE_W-1:0]),
        .B    (b_q[CSA_SLICE_W-1:0]),
        .cin  (carry_q),
        .cout (slice_cout),
        .sum  (slice_sum)
    );

    // On the final word the slice's bit 15 is the operand MSB, so the carry
    // into the MSB falls out of the sum bit without another adder.
    assign msb_cin = a_q[CSA_SLICE_W-1] ^ b_q[CSA_SLICE_W-1] ^ slice_sum[CSA_SLICE_W-1];
    assign res_d   = {slice_sum, res_q[N-1:CSA_SLICE_W]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b_eff;
            carry_q <= c_init;
            cnt_q   <= '0;
            res_q   <= '0;
        end else if (state_q == RUN) begin
            a_q     <= a_q >> CSA_SLICE_W;
            b_q     <= b_q >> CSA_SLICE_W;
            carry_q <= slice_cout;
            res_q   <= res_d;
            cnt_q   <= last ? '0 : cnt_q + 1'b1;
            if (last) begin
                sum_q  <= res_d;
                cout_q <= slice_cout;
                ovf_q  <= msb_cin ^ slice_cout;
            end
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_csa_wide_add_seq.sv
// Directed scoreboard bench for csa_wide_add_seq with WORDS=4.
module tb_csa_wide_add_seq;

    localparam int WORDS = 4;
    localparam int N     = 16 * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] a, b;
    logic         cin;
`ifdef CSA_SEQ_SUB_EN
    logic         sub;
`endif
    logic         busy, done, cout, ovf;
    logic [N-1:0] sum;

    typedef struct packed {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    res_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    csa_wide_add_seq #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef CSA_SEQ_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [N-1:0] av, input logic [N-1:0] bv,
                                   input logic cv, input logic sv);
        logic [N-1:0] bb;
        logic         c0;
        logic [N:0]   t;
        res_t         r;
        bb = sv ? ~bv : bv;
        c0 = sv ? 1'b1 : cv;
        t  = {1'b0, av} + {1'b0, bb} + (N+1)'(c0);
        r.sum  = t[N-1:0];
        r.cout = t[N];
        r.ovf  = av[N-1] ^ bb[N-1] ^ t[N-1] ^ t[N];
        return r;
    endfunction

    task automatic launch(input logic [N-1:0] av, input logic [N-1:0] bv,
                          input logic cv, input logic sv, input bit push);
        a     = av;
        b     = bv;
        cin   = cv;
`ifdef CSA_SEQ_SUB_EN
        sub   = sv;
`endif
        start = 1'b1;
        if (push) exp_q.push_back(model(av, bv, cv, sv));
    endtask

    // Entered at the first falling edge after the accepting edge.
    task automatic wait_result(input string tag, input bit poke_mid);
        int   n;
        res_t e;
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            if (n <= WORDS) check({tag, " busy"}, N'(busy), N'(1));
            @(negedge clk);
            n++;
            if (poke_mid && n == 2) begin
                start = 1'b1;
                a     = '1;
                b     = '1;
            end else begin
                start = 1'b0;
            end
        end
        check({tag, " latency"}, N'(n), N'(WORDS + 1));
        check({tag, " done"}, N'(done), N'(1));
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s scoreboard: observed empty expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, " sum"}, sum, e.sum);
            check({tag, " cout"}, N'(cout), N'(e.cout));
            check({tag, " ovf"}, N'(ovf), N'(e.ovf));
        end
    endtask

    task automatic idle_after(input string tag);
        @(negedge clk);
        check({tag, " done pulse end"}, N'(done), N'(0));
        check({tag, " idle busy"}, N'(busy), N'(0));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
`ifdef CSA_SEQ_SUB_EN
        sub   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst busy", N'(busy), N'(0));
        check("rst done", N'(done), N'(0));
        check("rst sum", sum, N'(0));
        check("rst cout", N'(cout), N'(0));
        check("rst ovf", N'(ovf), N'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle busy", N'(busy), N'(0));
        check("idle done", N'(done), N'(0));

        launch(64'h0000_0000_0000_001F, 64'h0000_0000_0000_000C, 1'b0, 1'b0, 1'b1);
        @(negedge clk); start = 1'b0;
        wait_result("small", 1'b0);
        idle_after("small");

        launch(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 1'b1);
        @(negedge clk); start = 1'b0;
        wait_result("ripple", 1'b0);
        idle_after("ripple");

        launch(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b1);
        @(negedge clk); start = 1'b0;
        wait_result("ovf", 1'b1);
        idle_after("ovf");

        launch(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0, 1'b1);
        @(negedge clk); start = 1'b0;
        wait_result("b2b first", 1'b0);
        launch(64'h9249_9249_9249_9249, 64'h9249_9249_9249_9249, 1'b1, 1'b0, 1'b1);
        @(negedge clk); start = 1'b0;
        wait_result("b2b second", 1'b0);
        idle_after("b2b");

        for (int i = 0; i < 3; i++) begin
            launch({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b0, 1'b1);
            @(negedge clk); start = 1'b0;
            wait_result("random", 1'b0);
        end
        idle_after("random");

`ifdef CSA_SEQ_SUB_EN
        launch(64'd5, 64'd7, 1'b0, 1'b1, 1'b1);
        @(negedge clk); start = 1'b0;
        wait_result("sub borrow", 1'b0);
        idle_after("sub borrow");
        launch(64'd7, 64'd5, 1'b0, 1'b1, 1'b1);
        @(negedge clk); start = 1'b0;
        wait_result("sub", 1'b0);
        idle_after("sub");
`endif

        launch(64'h0000_0000_0000_0003, 64'h0000_0000_0000_0004, 1'b0, 1'b0, 1'b0);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        check("abort busy before", N'(busy), N'(1));
        #2 rst = 1'b1;
        #1;
        check("abort busy", N'(busy), N'(0));
        check("abort sum", sum, N'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort no done", N'(done), N'(0));
        end
        check("scoreboard drained", N'(exp_q.size()), N'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
